// File: rtl/lzc_share_arb_if.sv
// Request/response bundle for lzc_share_arb.
// Optional resp_norm field present when LZC_SHARE_NORM_EN is defined.
interface lzc_share_arb_if #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 4,
  parameter int ID_W    = 3
);
  // Handshakes: a transfer happens on a rising clk edge where valid & ready are both 1.
  // Senders hold valid, data and tag stable until that edge; ready may depend on valid.
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*128-1:0]   req_data;
  logic [NUM_REQ*TAG_W-1:0] req_tag;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     resp_valid;
  logic                     resp_ready;
  logic [ID_W-1:0]          resp_id;
  logic [TAG_W-1:0]         resp_tag;
  logic [7:0]               resp_lz;
  logic                     resp_zero;
`ifdef LZC_SHARE_NORM_EN
  logic [127:0]             resp_norm;
`endif

  modport master (
    output req_valid, req_data, req_tag, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_tag, resp_lz, resp_zero
`ifdef LZC_SHARE_NORM_EN
    , resp_norm
`endif
  );

  modport slave (
    input  req_valid, req_data, req_tag, resp_ready,
    output req_ready, resp_valid, resp_id, resp_tag, resp_lz, resp_zero
`ifdef LZC_SHARE_NORM_EN
    , resp_norm
`endif
  );
endinterface

// File: rtl/lzc_share_arb.sv
// Round-robin arbiter sharing one lzc_128 among NUM_REQ requesters, one-deep response register.
// Define LZC_SHARE_NORM_EN to add the registered normalised operand resp_norm.
module lzc_128 (
  input  logic [127:0] d,
  output logic [6:0]   c,
  output logic         v
);
  always_comb begin
    c = '0;
    v = 1'b0;
    // Later (higher) set bits overwrite earlier ones, leaving the MSB index.
    for (int i = 0; i < 128; i++) begin
      if (d[i]) begin
        c = 7'(i);
        v = 1'b1;
      end
    end
  end
endmodule

module lzc_share_arb #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 4,
  parameter int ID_W    = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  lzc_share_arb_if.slave        bus,
  output logic [ID_W-1:0]       dbg_rr_ptr
);
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W:0]    cand;
  logic             gnt_found;
  logic [ID_W-1:0]  gnt_idx;
  logic [127:0]     gnt_data;
  logic [TAG_W-1:0] gnt_tag;
  logic [6:0]       lzc_c;
  logic             lzc_v;
  logic [7:0]       lz;
  logic             zero;
  logic             adv;
  logic             accept;

  logic             resp_valid_q;
  logic [ID_W-1:0]  resp_id_q;
  logic [TAG_W-1:0] resp_tag_q;
  logic [7:0]       resp_lz_q;
  logic             resp_zero_q;

  // Rotating search from rr_ptr; cand is one bit wider so the wrap cannot overflow.
  always_comb begin
    cand      = '0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    gnt_data  = '0;
    gnt_tag   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ)) cand = cand - (ID_W+1)'(NUM_REQ);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!gnt_found && cand == (ID_W+1)'(i) && bus.req_valid[i]) begin
          gnt_found = 1'b1;
          gnt_idx   = ID_W'(i);
          gnt_data  = bus.req_data[128*i +: 128];
          gnt_tag   = bus.req_tag[TAG_W*i +: TAG_W];
        end
      end
    end
  end

  assign adv    = ~resp_valid_q | bus.resp_ready;
  assign accept = gnt_found & adv & rst_n;

  always_comb begin
    bus.req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_ready[i] = accept && (gnt_idx == ID_W'(i));
    end
  end

  lzc_128 u_lzc (
    .d (gnt_data),
    .c (lzc_c),
    .v (lzc_v)
  );

  assign lz   = lzc_v ? (8'd127 - {1'b0, lzc_c}) : 8'd128;
  assign zero = ~lzc_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr       <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_tag_q   <= '0;
      resp_lz_q    <= '0;
      resp_zero_q  <= 1'b0;
    end else if (accept) begin
      rr_ptr       <= (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + ID_W'(1);
      resp_valid_q <= 1'b1;
      resp_id_q    <= gnt_idx;
      resp_tag_q   <= gnt_tag;
      resp_lz_q    <= lz;
      resp_zero_q  <= zero;
    end else if (bus.resp_ready) begin
      resp_valid_q <= 1'b0;
    end
  end

`ifdef LZC_SHARE_NORM_EN
  logic [127:0] norm_d;
  logic [127:0] resp_norm_q;

  // A shift by 128 clears the word, which covers the all-zero operand.
  assign norm_d = gnt_data << lz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) resp_norm_q <= '0;
    else if (accept) resp_norm_q <= norm_d;
  end

  assign bus.resp_norm = resp_norm_q;
`endif

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_tag   = resp_tag_q;
  assign bus.resp_lz    = resp_lz_q;
  assign bus.resp_zero  = resp_zero_q;
  assign dbg_rr_ptr     = rr_ptr;
endmodule

// File: tb/tb_lzc_share_arb.sv
// Scoreboard bench for lzc_share_arb: directed plan cases, backpressure, random traffic, async reset.
module tb_lzc_share_arb;
  localparam int NUM_REQ = 4;
  localparam int TAG_W   = 4;
  localparam int ID_W    = 3;
`ifdef LZC_SHARE_NORM_EN
  localparam int EXP_W = ID_W + TAG_W + 9 + 128;
`else
  localparam int EXP_W = ID_W + TAG_W + 9;
`endif

  logic            clk;
  logic            rst_n;
  logic [ID_W-1:0] dbg_rr_ptr;

  lzc_share_arb_if #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .ID_W(ID_W)) bus ();

  lzc_share_arb #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .ID_W(ID_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .dbg_rr_ptr (dbg_rr_ptr)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;

  logic [EXP_W-1:0] exp_q[$];
  int   mdl_ptr  = 0;
  bit   mdl_rv   = 0;
  bit   prev_acc = 0;
  int   prev_g   = 0;
  int   mode     = 0;   // 0: drop after accept, 1: hold same request, 2: random
  bit   ready_cfg = 1;

  task automatic chk(input string name, input logic [319:0] got, input logic [319:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic int model_lz(input logic [127:0] d);
    int n = 0;
    while (n < 128 && d[127-n] == 1'b0) n++;
    return n;
  endfunction

  function automatic logic [EXP_W-1:0] pack_exp(input int id, input logic [127:0] d,
                                                 input logic [TAG_W-1:0] t);
    int n;
    logic [127:0] nrm;
    n = model_lz(d);
    nrm = '0;
    if (n < 128) nrm = d << n;
`ifdef LZC_SHARE_NORM_EN
    return {ID_W'(id), t, 8'(n), (n == 128), nrm};
`else
    return {ID_W'(id), t, 8'(n), (n == 128)};
`endif
  endfunction

  function automatic logic [EXP_W-1:0] pack_dut();
`ifdef LZC_SHARE_NORM_EN
    return {bus.resp_id, bus.resp_tag, bus.resp_lz, bus.resp_zero, bus.resp_norm};
`else
    return {bus.resp_id, bus.resp_tag, bus.resp_lz, bus.resp_zero};
`endif
  endfunction

  function automatic logic [127:0] gen_data();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    case ($urandom_range(0, 3))
      0: return '0;
      1: return 128'h1 << $urandom_range(0, 127);
      2: return r >> $urandom_range(0, 127);
      default: return r;
    endcase
  endfunction

  // driver tasks
  task automatic set_req(input int i, input logic [127:0] d, input logic [TAG_W-1:0] t);
    bus.req_data[128*i +: 128]    = d;
    bus.req_tag[TAG_W*i +: TAG_W] = t;
    bus.req_valid[i]              = 1'b1;
  endtask

  // Called at a falling edge: drive, check, let the rising edge happen, retire the accept.
  task automatic step();
    logic [NUM_REQ-1:0] exp_rdy;
    int  g;
    bit  any, adv, drain;
    if (mode == 2) begin
      for (int i = 0; i < NUM_REQ; i++)
        if (!bus.req_valid[i] && $urandom_range(0, 2) == 0)
          set_req(i, gen_data(), TAG_W'($urandom));
      bus.resp_ready = ($urandom_range(0, 3) != 0);
    end else begin
      bus.resp_ready = ready_cfg;
    end
    #1;
    chk("resp_valid", bus.resp_valid, mdl_rv);
    if (mdl_rv) begin
      if (exp_q.size() == 0) chk("q_size", exp_q.size(), 1);
      else chk("resp", pack_dut(), exp_q[0]);
    end
    chk("rr_ptr", dbg_rr_ptr, mdl_ptr);
    adv = !mdl_rv || bus.resp_ready;
    any = 0;
    g   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int c;
      c = (mdl_ptr + k) % NUM_REQ;
      if (!any && bus.req_valid[c]) begin
        any = 1;
        g   = c;
      end
    end
    exp_rdy = '0;
    if (any && adv) exp_rdy[g] = 1'b1;
    chk("req_ready", bus.req_ready, exp_rdy);
    drain = mdl_rv && bus.resp_ready;
    if (drain && exp_q.size() > 0) void'(exp_q.pop_front());
    if (any && adv) begin
      exp_q.push_back(pack_exp(g, bus.req_data[128*g +: 128], bus.req_tag[TAG_W*g +: TAG_W]));
      mdl_ptr = (g + 1) % NUM_REQ;
      mdl_rv  = 1;
    end else if (drain) begin
      mdl_rv = 0;
    end
    prev_acc = any && adv;
    prev_g   = g;
    @(posedge clk);
    @(negedge clk);
    if (prev_acc) begin
      case (mode)
        0: bus.req_valid[prev_g] = 1'b0;
        1: ;
        default: begin
          if ($urandom_range(0, 1) == 0) bus.req_valid[prev_g] = 1'b0;
          else set_req(prev_g, gen_data(), TAG_W'($urandom));
        end
      endcase
    end
  endtask

  initial begin
    int lzw[NUM_REQ];
    lzw = '{5, 31, 64, 100};
    rst_n          = 1'b0;
    bus.req_valid  = '1;
    bus.req_data   = '0;
    bus.req_tag    = '0;
    bus.resp_ready = 1'b1;
    #3;
    chk("rst_resp", pack_dut(), '0);
    chk("rst_valid", bus.resp_valid, 1'b0);
    chk("rst_ready", bus.req_ready, '0);
    chk("rst_ptr", dbg_rr_ptr, 0);
    bus.req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // directed single-requester cases
    mode = 0;
    ready_cfg = 1;
    set_req(0, 128'h1, 4'h5);
    step();
    #1;
    chk("lz127", bus.resp_lz, 127);
    chk("id0", bus.resp_id, 0);
    chk("zero0", bus.resp_zero, 0);
    step();
    set_req(2, {1'b1, 127'b0}, 4'hA);
    step();
    #1;
    chk("lz0", bus.resp_lz, 0);
    chk("id2", bus.resp_id, 2);
    chk("tagA", bus.resp_tag, 4'hA);
`ifdef LZC_SHARE_NORM_EN
    chk("norm_msb", bus.resp_norm, {1'b1, 127'b0});
`endif
    step();
    set_req(3, '0, 4'h3);
    step();
    #1;
    chk("lz128", bus.resp_lz, 128);
    chk("zero1", bus.resp_zero, 1);
`ifdef LZC_SHARE_NORM_EN
    chk("norm_zero", bus.resp_norm, '0);
`endif
    step();

    // all four continuously valid: 0,1,2,3,0 at one per cycle
    mode = 1;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 128'h1 << (127 - lzw[i]), TAG_W'(i + 8));
    step();
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("order", bus.resp_id, k % NUM_REQ);
      chk("order_lz", bus.resp_lz, lzw[k % NUM_REQ]);
      step();
    end

    // backpressure, then release with drain and accept in the same cycle
    ready_cfg = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      #1;
      chk("bp_ready", bus.req_ready, '0);
    end
    ready_cfg = 1;
    for (int k = 0; k < 4; k++) step();

    // random traffic
    mode = 2;
    for (int k = 0; k < 400; k++) step();

    // hold a response, then pulse reset mid-cycle
    mode = 0;
    ready_cfg = 0;
    for (int k = 0; k < 3; k++) step();
    if (!bus.req_valid[1]) set_req(1, 128'hFF, 4'h7);
    step();
    step();
    #7;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", bus.resp_valid, 1'b0);
    chk("arst_ready", bus.req_ready, '0);
    chk("arst_ptr", dbg_rr_ptr, 0);
    bus.req_valid = '0;
    exp_q.delete();
    mdl_rv   = 0;
    mdl_ptr  = 0;
    prev_acc = 0;
    @(negedge clk);
    rst_n = 1'b1;
    ready_cfg = 1;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 128'h1 << (127 - lzw[i]), TAG_W'(i));
    #1;
    chk("post_rst_gnt", bus.req_ready, 4'b0001);
    step();
    for (int k = 0; k < 4; k++) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
